// File: rtl/merge_buf_issue_sched.sv
// merge_buf_issue_sched
//   Issue scheduler sitting between the request merge buffer and the
//   downstream memory port. Every newly allocated buffer entry is tracked and
//   issued exactly once. The scan is round-robin over entry index, and the
//   number of requests that are reserved (held in the output slot) or in
//   flight is capped at MAX_OUT. A downstream response retires its entry and
//   produces a one-cycle release pulse back to the merge buffer.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   alloc_valid/entry/addr   per-port allocation notifications from the buffer
//   dn_req_valid/ready/addr/tag   downstream request (registered output slot)
//   dn_rsp_valid/tag         downstream response, always accepted
//   release_valid/entry      one-cycle release pulse to the merge buffer
//   out_cnt                  reserved + in-flight request count
//   idle                     nothing pending, slot empty, out_cnt == 0
//   err_dup_alloc            sticky: alloc hit a busy entry or a same-cycle twin
//   err_bad_rsp              sticky: response tag was not a retireable entry
module merge_buf_issue_sched #(
  parameter  int ENTRY_NUM = 32,
  parameter  int PORT_NUM  = 4,
  parameter  int ADDR_W    = 32,
  parameter  int MAX_OUT   = 8,
  localparam int IDX_W     = $clog2(ENTRY_NUM),
  localparam int CNT_W     = $clog2(MAX_OUT + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORT_NUM-1:0]              alloc_valid,
  input  logic [PORT_NUM-1:0][IDX_W-1:0]   alloc_entry,
  input  logic [PORT_NUM-1:0][ADDR_W-1:0]  alloc_addr,
  output logic                             dn_req_valid,
  input  logic                             dn_req_ready,
  output logic [ADDR_W-1:0]                dn_req_addr,
  output logic [IDX_W-1:0]                 dn_req_tag,
  input  logic                             dn_rsp_valid,
  input  logic [IDX_W-1:0]                 dn_rsp_tag,
  output logic                             release_valid,
  output logic [IDX_W-1:0]                 release_entry,
  output logic [CNT_W-1:0]                 out_cnt,
  output logic                             idle,
  output logic                             err_dup_alloc,
  output logic                             err_bad_rsp
);

  // Per-entry state, gathered into flat vectors for the shared logic.
  logic [ENTRY_NUM-1:0]             pend_v;
  logic [ENTRY_NUM-1:0]             infl_v;
  logic [ENTRY_NUM-1:0]             busy_v;
  logic [ENTRY_NUM-1:0][ADDR_W-1:0] ent_addr;

  // Per-entry control strobes.
  logic [ENTRY_NUM-1:0]             alloc_set;
  logic [ENTRY_NUM-1:0][ADDR_W-1:0] alloc_wdata;
  logic [ENTRY_NUM-1:0]             issue_v;
  logic [ENTRY_NUM-1:0]             retire_v;

  logic                             dup_hit;
  logic                             rsp_good;
  logic                             slot_free;
  logic                             do_issue;
  logic [CNT_W-1:0]                 cnt_after;

  logic [IDX_W-1:0]                 rr_ptr;
  logic [ENTRY_NUM-1:0]             pend_rot;
  logic [IDX_W-1:0]                 pick_off;
  logic [IDX_W-1:0]                 pick_idx;
  logic                             pick_found;

  assign busy_v = pend_v | infl_v;

  // ---------------------------------------------------------------------------
  // Allocation decode. Decisions use the state at the start of the cycle, so
  // an entry that is pending or in flight (including the one held in the
  // output slot) is never overwritten. Among ports naming the same free entry
  // the lowest port claims it and every later one flags a duplicate.
  // ---------------------------------------------------------------------------
  always_comb begin
    alloc_set   = '0;
    alloc_wdata = '0;
    dup_hit     = 1'b0;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (alloc_valid[p]) begin
        if (busy_v[alloc_entry[p]] || alloc_set[alloc_entry[p]]) begin
          dup_hit = 1'b1;
        end else begin
          alloc_set[alloc_entry[p]]   = 1'b1;
          alloc_wdata[alloc_entry[p]] = alloc_addr[p];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response check. The entry held in the output slot is marked in flight but
  // has not been seen downstream yet, so a response naming it is bogus.
  // ---------------------------------------------------------------------------
  assign rsp_good = dn_rsp_valid && infl_v[dn_rsp_tag] &&
                    !(dn_req_valid && (dn_req_tag == dn_rsp_tag));

  // ---------------------------------------------------------------------------
  // Round-robin pick: rotate pending so rr_ptr lands on bit 0, take the lowest
  // set bit, then rotate the offset back. Index arithmetic wraps naturally
  // because ENTRY_NUM is a power of two.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_rot   = '0;
    pick_off   = '0;
    pick_found = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      pend_rot[i] = pend_v[rr_ptr + IDX_W'(i)];
    end
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (!pick_found && pend_rot[i]) begin
        pick_off   = IDX_W'(i);
        pick_found = 1'b1;
      end
    end
  end

  assign pick_idx = rr_ptr + pick_off;

  // A retiring response frees its credit in the same cycle, so the slot can
  // reload immediately after the cap was reached.
  assign cnt_after = out_cnt - CNT_W'(rsp_good);
  assign slot_free = !dn_req_valid || dn_req_ready;
  assign do_issue  = slot_free && pick_found && (cnt_after < CNT_W'(MAX_OUT));

  // ---------------------------------------------------------------------------
  // Entry array. pending and in-flight are mutually exclusive: issue moves an
  // entry from pending to in flight, retire clears in flight, and alloc only
  // lands on an entry that is neither.
  // ---------------------------------------------------------------------------
  for (genvar e = 0; e < ENTRY_NUM; e++) begin : g_ent
    logic              pend_q;
    logic              infl_q;
    logic [ADDR_W-1:0] addr_q;

    assign issue_v[e]  = do_issue && (pick_idx == IDX_W'(e));
    assign retire_v[e] = rsp_good && (dn_rsp_tag == IDX_W'(e));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_q <= 1'b0;
        infl_q <= 1'b0;
      end else begin
        pend_q <= (pend_q & ~issue_v[e]) | alloc_set[e];
        infl_q <= (infl_q & ~retire_v[e]) | issue_v[e];
      end
    end

    // Address storage is only read for entries that were written first.
    always_ff @(posedge clk) begin
      if (alloc_set[e]) addr_q <= alloc_wdata[e];
    end

    assign pend_v[e]   = pend_q;
    assign infl_v[e]   = infl_q;
    assign ent_addr[e] = addr_q;
  end

  // ---------------------------------------------------------------------------
  // Output slot, credit counter, release pulse and sticky errors.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_req_valid  <= 1'b0;
      dn_req_addr   <= '0;
      dn_req_tag    <= '0;
      rr_ptr        <= '0;
      out_cnt       <= '0;
      release_valid <= 1'b0;
      release_entry <= '0;
      err_dup_alloc <= 1'b0;
      err_bad_rsp   <= 1'b0;
    end else begin
      if (do_issue) begin
        dn_req_valid <= 1'b1;
        dn_req_addr  <= ent_addr[pick_idx];
        dn_req_tag   <= pick_idx;
        rr_ptr       <= pick_idx + 1'b1;
      end else if (dn_req_ready) begin
        dn_req_valid <= 1'b0;
      end

      out_cnt       <= cnt_after + CNT_W'(do_issue);
      release_valid <= rsp_good;
      if (rsp_good) release_entry <= dn_rsp_tag;

      if (dup_hit) err_dup_alloc <= 1'b1;
      if (dn_rsp_valid && !rsp_good) err_bad_rsp <= 1'b1;
    end
  end

  assign idle = ~|pend_v && !dn_req_valid && (out_cnt == '0);

endmodule
